// File: rtl/carregador_matrizes.sv
// carregador_matrizes: reads two NxN byte matrices from data memory
// into zero-padded 5x5 flat operands for the matrix ALU.
module carregador_matrizes #(
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        tamanho,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [199:0]      matriz_a,
  output logic [199:0]      matriz_b,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, nxt;

  logic [2:0]        r, c, n, n_in;
  logic [ADDR_W-1:0] ba, bb, base_sel;
  logic [ADDR_W-1:0] elem, last_addr;
  logic [4:0]        slot, ws;
  logic              wv, wb, wrd;
  logic              loading, in_range;
  logic              last_slot, accept;
  logic [7:0]        wdata;

  // clamp illegal sizes to a full 5x5 load
  always_comb begin
    n_in = tamanho;
    if (tamanho == 3'd0 || tamanho > 3'd5)
      n_in = 3'd5;
  end

  // slot decode, element address and read strobe
  always_comb begin
    loading   = (state == S_LOAD_A) ||
                (state == S_LOAD_B);
    in_range  = (r < n) && (c < n);
    last_slot = (r == 3'd4) && (c == 3'd4);
    slot      = 5'(r) * 5'd5 + 5'(c);
    base_sel  = (state == S_LOAD_B) ? bb : ba;
    elem      = base_sel
              + ADDR_W'(r) * ADDR_W'(n)
              + ADDR_W'(c);
    mem_rd    = loading && in_range;
    mem_addr  = mem_rd ? elem : last_addr;
    accept    = (state == S_IDLE) && start;
    wdata     = wrd ? mem_data : 8'd0;
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= nxt;
  end

  // next state and status outputs
  always_comb begin
    nxt  = state;
    busy = 1'b1;
    done = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start)
          nxt = S_LOAD_A;
      end
      S_LOAD_A:
        if (last_slot)
          nxt = S_LOAD_B;
      S_LOAD_B:
        if (last_slot)
          nxt = S_DRAIN;
      S_DRAIN:
        nxt = S_DONE;
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default:
        nxt = S_IDLE;
    endcase
  end

  // slot counter, latched operands and one-cycle write pipeline
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r         <= 3'd0;
      c         <= 3'd0;
      n         <= 3'd0;
      ba        <= '0;
      bb        <= '0;
      last_addr <= '0;
      wv        <= 1'b0;
      wb        <= 1'b0;
      wrd       <= 1'b0;
      ws        <= 5'd0;
      matriz_a  <= '0;
      matriz_b  <= '0;
    end else begin
      wv  <= loading;
      wb  <= (state == S_LOAD_B);
      wrd <= mem_rd;
      ws  <= slot;
      if (mem_rd)
        last_addr <= elem;
      if (accept) begin
        n        <= n_in;
        ba       <= base_a;
        bb       <= base_b;
        r        <= 3'd0;
        c        <= 3'd0;
        matriz_a <= '0;
        matriz_b <= '0;
      end else if (loading) begin
        if (c == 3'd4) begin
          c <= 3'd0;
          r <= (r == 3'd4) ? 3'd0 : r + 3'd1;
        end else begin
          c <= c + 3'd1;
        end
      end
      if (wv) begin
        if (wb)
          matriz_b[{ws, 3'b000} +: 8] <= wdata;
        else
          matriz_a[{ws, 3'b000} +: 8] <= wdata;
      end
    end
  end

endmodule

// File: doc/carregador_matrizes.md
# carregador_matrizes

Operand loader for the matrix ALU. On a start pulse, it reads matrix A, then matrix B, from synchronous byte-wide data memory, one element per cycle. It assembles each into the 200-bit flat 5×5 operand format that the ALU arithmetic stages consume (element-wise add/subtract). Matrices smaller than 5×5 are zero-padded. The block reports completion with a one-cycle `done` pulse.

## Interface
- `ADDR_W`, default 9: memory address width.
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a load; sampled only in IDLE.
- `tamanho`  in  3: matrix dimension N, sampled with `start`. Legal values are 1..5; 0, 6 and 7 are treated as 5.
- `base_a`  in  ADDR_W: address of A(0,0), sampled with `start`.
- `base_b`  in  ADDR_W: address of B(0,0), sampled with `start`.
- `mem_addr`  out  ADDR_W: read address.
- `mem_rd`  out  1: read strobe.
- `mem_data`  in  8: read data, valid exactly one cycle after `mem_rd`.
- `matriz_a`  out  200: assembled A.
- `matriz_b`  out  200: assembled B.
- `busy`  out  1: a load is in progress.
- `done`  out  1: one-cycle completion pulse.

## Operation
- **Memory layout:** each source matrix is packed row-major as N×N bytes. Element (r,c) is at `base + r*N + c`, truncated modulo 2^ADDR_W, so addresses wrap at the top of memory.
- **Output layout:** element (r,c) of the output occupies bits `[(r*5+c)*8 +: 8]` for every N. Positions with r≥N or c≥N are 0.
- **States:** IDLE, LOAD_A, LOAD_B, DRAIN, DONE.
- **IDLE:** `busy`=0, `done`=0.
  - `start`=1 → latch `tamanho`, `base_a`, `base_b`; clear `matriz_a` and `matriz_b` to 0; set k=0; go to LOAD_A.
- **LOAD_A / LOAD_B:** slot counter k runs 0..24, one slot per cycle, with r=k/5 and c=k%5.
  - If r<N and c<N: `mem_rd`=1 and `mem_addr` = element address.
  - Otherwise: `mem_rd`=0 and `mem_addr` holds its previous value.
  - LOAD_A at k=24 → LOAD_B with k=0. LOAD_B at k=24 → DRAIN.
- **Write pipeline:** the slot index and a target flag (A or B) are registered one cycle. In the following cycle, the slot is written with `mem_data` if it was read, or with 0 otherwise.
- **DRAIN:** performs the write for B slot 24. `mem_rd`=0. Go to DONE.
- **DONE:** `done`=1 for exactly one cycle, `busy`=1, then go to IDLE.
- **Between loads:** `matriz_a` and `matriz_b` hold their values until the next accepted `start`.
- **Ignored start:** `start` while `busy`=1 has no effect.
- **Stable inputs:** changes to `tamanho`, `base_a` or `base_b` after acceptance do not affect the load in progress.

## Timing
- **Reset:** asserting `reset_n`=0 at any time, including mid-load, forces IDLE immediately. All outputs go to 0: `matriz_a`, `matriz_b`, `mem_addr`, `mem_rd`, `busy`, `done`. The registered pipeline slot is discarded, and no `done` is produced for the aborted load.
- **Cycle numbering:** `start` is sampled at edge 0.
- **LOAD_A:** cycles 1..25 (slot k in cycle k+1).
- **LOAD_B:** cycles 26..50.
- **DRAIN:** cycle 51.
- **DONE:** `done` is high in cycle 52, and IDLE is re-entered at cycle 53.
- **Fixed latency:** the load always takes 52 cycles from start to `done`, independent of N.
- **Data capture:** `mem_data` is captured on the edge ending the cycle after its `mem_rd`.
- **Earliest restart:** a new `start` is accepted in cycle 53.
- **`busy`:** high in cycles 1..52.
- **Output validity:** `matriz_a` and `matriz_b` are complete and stable from the first cycle of `done` onward. Intermediate values during the load are not meaningful.
- **Read count:** exactly N² reads for A, then N² reads for B. There are never two reads for the same slot.

## Test plan
- **Full 5×5 load:** reset, then start with N=5, base_a=0x000, base_b=0x019. Memory holds mem[i]=i. → 50 `mem_rd` pulses at addresses 0x000..0x031 in order. `matriz_a` byte k = k, `matriz_b` byte k = 25+k, and `done` is high in cycle 52.
- **Zero-fill, 3×3:** N=3, base_a=0x100, base_b=0x110, memory filled with 0xFF. → 9 reads per matrix, at 0x100..0x108 and 0x110..0x118. Bytes 0,1,2,5,6,7,10,11,12 = 0xFF, all other bytes = 0. `done` still in cycle 52.
- **Address wrap:** N=5, base_a=0x1F0. → A read addresses run 0x1F0..0x1FF, then 0x000..0x008.
- **Clamped size and ignored start:** N=0 → behaves exactly as N=5. A second `start` in cycle 10 is ignored and `busy` stays high.
- **Reset mid-load:** reset_n low in cycle 30. → All outputs are 0 immediately and no `done` is produced. A subsequent start with N=2 gives only bytes 0,1,5,6 nonzero in each matrix.
- **Back-to-back loads:** a second start in cycle 53 with different data. → The previous matrices are held until cycle 53, then cleared. The second `done` is in cycle 105.
